// File: rtl/fft_pkg.sv
// Shared constants, state type and index helpers for the 16-point FFT
// load/unload blocks. The 8-point variant reuses bitrev4 with width 3.
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int LOG2N      = 4;
  localparam int FFT_DATA_W = 32;

  // Stream counter value that marks the final word of a frame.
  localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(FFT_N - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  // Reverse the low 'width' bits of v (width <= LOG2N). The full 4-bit
  // reversal is shifted down so narrower transforms land in the low bits.
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v,
                                               input int               width);
    logic [LOG2N-1:0] full;
    full = {v[0], v[1], v[2], v[3]};
    return full >> (LOG2N - width);
  endfunction

endpackage

// File: rtl/unload_data.sv
// Drain end of the 16-point FFT: captures one parallel result frame on a
// ready pulse and streams it out word by word over valid/ready, optionally
// undoing the bit-reversed bin order of the butterfly network.
module unload_data
  import fft_pkg::*;
#(
  parameter int DATA_W  = FFT_DATA_W,
  parameter bit BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              rdy_fft,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] y1,
  input  logic [DATA_W-1:0] y2,
  input  logic [DATA_W-1:0] y3,
  input  logic [DATA_W-1:0] y4,
  input  logic [DATA_W-1:0] y5,
  input  logic [DATA_W-1:0] y6,
  input  logic [DATA_W-1:0] y7,
  input  logic [DATA_W-1:0] y8,
  input  logic [DATA_W-1:0] y9,
  input  logic [DATA_W-1:0] y10,
  input  logic [DATA_W-1:0] y11,
  input  logic [DATA_W-1:0] y12,
  input  logic [DATA_W-1:0] y13,
  input  logic [DATA_W-1:0] y14,
  input  logic [DATA_W-1:0] y15,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic [LOG2N-1:0]  dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              done,
  output logic              overrun
);

  state_e            state_q;
  logic [LOG2N-1:0]  cnt_q;
  logic              overrun_q;
  logic [DATA_W-1:0] frame_q [FFT_N];
  logic [DATA_W-1:0] yIn     [FFT_N];
  logic              accept;
  logic              streaming;
  logic [LOG2N-1:0]  addr;

  assign yIn[0]  = y0;
  assign yIn[1]  = y1;
  assign yIn[2]  = y2;
  assign yIn[3]  = y3;
  assign yIn[4]  = y4;
  assign yIn[5]  = y5;
  assign yIn[6]  = y6;
  assign yIn[7]  = y7;
  assign yIn[8]  = y8;
  assign yIn[9]  = y9;
  assign yIn[10] = y10;
  assign yIn[11] = y11;
  assign yIn[12] = y12;
  assign yIn[13] = y13;
  assign yIn[14] = y14;
  assign yIn[15] = y15;

  // A frame is taken only when idle and enabled; anything else is dropped.
  assign accept    = (state_q == IDLE) && rdy_fft && enable;
  assign streaming = (state_q == STREAM);

  // Buffer address: bit-reversed counter gives natural-order bins.
  always_comb begin
    addr = cnt_q;
    if (BIT_REV) begin
      addr = bitrev4(cnt_q, LOG2N);
    end
  end

  // Control FSM: capture, stream 16 words under backpressure, one DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rdy_fft && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (dout_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Frame buffer: written only on accept, otherwise holds its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FFT_N; i++) begin
        frame_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < FFT_N; i++) begin
        frame_q[i] <= yIn[i];
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign dout_valid = streaming;
  assign dout       = streaming ? frame_q[addr] : '0;
  assign dout_idx   = streaming ? addr : '0;
  assign dout_last  = streaming && (cnt_q == LAST_CNT);
  assign done       = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_unload_data.sv
// Testbench for unload_data: two instances (straight and bit-reversed order)
// share all inputs; a scoreboard holds the expected word sequence per instance.
`timescale 1ns/1ps
module tb_unload_data;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        rdy_fft;
  logic        dout_ready;
  logic [31:0] yDrv [16];

  logic        busyN, validN, lastN, doneN, overrunN;
  logic [31:0] doutN;
  logic [3:0]  idxN;
  logic        busyR, validR, lastR, doneR, overrunR;
  logic [31:0] doutR;
  logic [3:0]  idxR;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] word;
    logic        last;
  } sbEntry_t;

  sbEntry_t sbN[$];
  sbEntry_t sbR[$];
  sbEntry_t monE;

  int testsRun    = 0;
  int testsFailed = 0;
  int xferCnt     = 0;

  bit          holding = 1'b0;
  logic [31:0] holdDoutN, holdDoutR;
  logic [3:0]  holdIdxN, holdIdxR;
  logic        holdLastN, holdLastR;

  // 100 MHz clock.
  always #5 clk = ~clk;

  unload_data #(.DATA_W(32), .BIT_REV(1'b0)) dutN (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rdy_fft(rdy_fft),
    .y0(yDrv[0]), .y1(yDrv[1]), .y2(yDrv[2]), .y3(yDrv[3]),
    .y4(yDrv[4]), .y5(yDrv[5]), .y6(yDrv[6]), .y7(yDrv[7]),
    .y8(yDrv[8]), .y9(yDrv[9]), .y10(yDrv[10]), .y11(yDrv[11]),
    .y12(yDrv[12]), .y13(yDrv[13]), .y14(yDrv[14]), .y15(yDrv[15]),
    .busy(busyN), .dout(doutN), .dout_idx(idxN), .dout_valid(validN),
    .dout_ready(dout_ready), .dout_last(lastN), .done(doneN), .overrun(overrunN)
  );

  unload_data #(.DATA_W(32), .BIT_REV(1'b1)) dutR (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rdy_fft(rdy_fft),
    .y0(yDrv[0]), .y1(yDrv[1]), .y2(yDrv[2]), .y3(yDrv[3]),
    .y4(yDrv[4]), .y5(yDrv[5]), .y6(yDrv[6]), .y7(yDrv[7]),
    .y8(yDrv[8]), .y9(yDrv[9]), .y10(yDrv[10]), .y11(yDrv[11]),
    .y12(yDrv[12]), .y13(yDrv[13]), .y14(yDrv[14]), .y15(yDrv[15]),
    .busy(busyR), .dout(doutR), .dout_idx(idxR), .dout_valid(validR),
    .dout_ready(dout_ready), .dout_last(lastR), .done(doneR), .overrun(overrunR)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bin order of a bit-reversed FFT: reverse the four index bits.
  function automatic logic [3:0] revIdx(input int k);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b] = k[3-b];
    end
    return r;
  endfunction

  // Drives one rdy_fft pulse with a fresh frame; when acceptance is expected
  // the word order each instance should emit is queued. Entered at posedge+1.
  task automatic applyStimulus(input logic [15:0] hiBase, input logic [15:0] loBase,
                               input bit expectAccept);
    sbEntry_t e;
    for (int k = 0; k < 16; k++) begin
      yDrv[k] = {hiBase + 16'(k), loBase + 16'(k)};
    end
    rdy_fft = 1'b1;
    if (expectAccept) begin
      xferCnt = 0;
      for (int k = 0; k < 16; k++) begin
        e.idx  = 4'(k);
        e.word = yDrv[k];
        e.last = (k == 15);
        sbN.push_back(e);
        e.idx  = revIdx(k);
        e.word = yDrv[revIdx(k)];
        sbR.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    rdy_fft = 1'b0;
  endtask

  // Runs a frame to completion with a given sink behaviour:
  // 0 ready high, 1 backpressure pattern, 2 overrun injection, 3 stop at cnt 9.
  task automatic streamFrame(input int mode);
    int cyc      = 0;
    int phase    = 0;
    int holdLeft = 5;
    bit injected = 1'b0;
    bit doneSeen = 1'b0;
    while (!doneSeen && cyc < 200) begin
      if (mode == 3 && xferCnt == 9) begin
        return;
      end
      rdy_fft    = 1'b0;
      dout_ready = 1'b1;
      if (mode == 1) begin
        if (xferCnt == 7 && holdLeft > 0) begin
          dout_ready = 1'b0;
          holdLeft--;
        end else begin
          dout_ready = (phase % 3 == 0);
          phase++;
        end
      end else if (mode == 2 && xferCnt == 3 && !injected) begin
        for (int k = 0; k < 16; k++) begin
          yDrv[k] = 32'hDEAD_0000 | 32'(k);
        end
        rdy_fft  = 1'b1;
        injected = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (xferCnt == 16) begin
        doneSeen = 1'b1;
        checkOutput("doneN", doneN, 1);
        checkOutput("doneR", doneR, 1);
        checkOutput("validAtDoneN", validN, 0);
        checkOutput("busyAtDoneN", busyN, 1);
      end
    end
    rdy_fft = 1'b0;
    checkOutput("xferCount", xferCnt, 16);
    checkOutput("sbLeftN", sbN.size(), 0);
    checkOutput("sbLeftR", sbR.size(), 0);
    if (mode == 0 || mode == 2) begin
      checkOutput("doneLatency", cyc, 16);
    end
    @(posedge clk);
    #1;
    checkOutput("busyAfterN", busyN, 0);
    checkOutput("doneAfterN", doneN, 0);
    checkOutput("busyAfterR", busyR, 0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks that stalled
  // outputs do not move while the sink holds ready low.
  always @(negedge clk) begin
    if (holding) begin
      checkOutput("holdDoutN", doutN, holdDoutN);
      checkOutput("holdIdxN", idxN, holdIdxN);
      checkOutput("holdLastN", lastN, holdLastN);
      checkOutput("holdValidN", validN, 1);
      checkOutput("holdDoutR", doutR, holdDoutR);
      checkOutput("holdIdxR", idxR, holdIdxR);
      checkOutput("holdLastR", lastR, holdLastR);
    end
    holding = 1'b0;
    if (validN && dout_ready) begin
      if (sbN.size() == 0) begin
        checkOutput("spuriousXferN", validN, 0);
      end else begin
        monE = sbN.pop_front();
        checkOutput("doutN", doutN, monE.word);
        checkOutput("idxN", idxN, monE.idx);
        checkOutput("lastN", lastN, monE.last);
      end
      xferCnt++;
    end else if (validN) begin
      holding   = 1'b1;
      holdDoutN = doutN;
      holdIdxN  = idxN;
      holdLastN = lastN;
      holdDoutR = doutR;
      holdIdxR  = idxR;
      holdLastR = lastR;
    end
    if (validR && dout_ready) begin
      if (sbR.size() == 0) begin
        checkOutput("spuriousXferR", validR, 0);
      end else begin
        monE = sbR.pop_front();
        checkOutput("doutR", doutR, monE.word);
        checkOutput("idxR", idxR, monE.idx);
        checkOutput("lastR", lastR, monE.last);
      end
    end
  end

  // Directed sequence.
  initial begin
    reset_n    = 1'b0;
    enable     = 1'b1;
    rdy_fft    = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      yDrv[k] = '0;
    end

    // Reset held 200 ns with rdy_fft pulsing: nothing may leave reset state.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      rdy_fft = c[0];
      for (int k = 0; k < 16; k++) begin
        yDrv[k] = $urandom;
      end
    end
    rdy_fft = 1'b0;
    checkOutput("rstBusyN", busyN, 0);
    checkOutput("rstValidN", validN, 0);
    checkOutput("rstDoutN", doutN, 0);
    checkOutput("rstIdxN", idxN, 0);
    checkOutput("rstLastN", lastN, 0);
    checkOutput("rstDoneN", doneN, 0);
    checkOutput("rstOverrunN", overrunN, 0);
    checkOutput("rstValidR", validR, 0);
    checkOutput("rstOverrunR", overrunR, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleValidN", validN, 0);
    checkOutput("idleBusyN", busyN, 0);

    // Natural and bit-reversed order, sink always ready.
    applyStimulus(16'h0000, 16'h0100, 1'b1);
    checkOutput("firstValidN", validN, 1);
    checkOutput("firstValidR", validR, 1);
    checkOutput("firstDoutN", doutN, 32'h0000_0100);
    streamFrame(0);

    // rdy_fft with enable low in IDLE is ignored without a flag.
    enable = 1'b0;
    applyStimulus(16'h7777, 16'h8888, 1'b0);
    checkOutput("enOffBusyN", busyN, 0);
    checkOutput("enOffValidN", validN, 0);
    checkOutput("enOffOverrunN", overrunN, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("enOffValidLater", validN, 0);
    enable = 1'b1;

    // Backpressure with a long stall at cnt 7.
    applyStimulus(16'h1200, 16'h3400, 1'b1);
    streamFrame(1);
    checkOutput("bpOverrunN", overrunN, 0);

    // Second frame arriving mid-stream is discarded and flagged.
    dout_ready = 1'b1;
    applyStimulus(16'h5500, 16'h6600, 1'b1);
    streamFrame(2);
    checkOutput("overrunN", overrunN, 1);
    checkOutput("overrunR", overrunR, 1);

    // Asynchronous reset between edges aborts the stream at cnt 9.
    applyStimulus(16'hA000, 16'h5000, 1'b1);
    streamFrame(3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstValidN", validN, 0);
    checkOutput("midRstBusyN", busyN, 0);
    checkOutput("midRstValidR", validR, 0);
    checkOutput("midRstOverrunN", overrunN, 0);
    sbN.delete();
    sbR.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postRstValidN", validN, 0);
    checkOutput("postRstBusyN", busyN, 0);

    // A fresh frame after the abort streams from index 0.
    applyStimulus(16'hC000, 16'h0C00, 1'b1);
    checkOutput("restartIdxN", idxN, 0);
    checkOutput("restartIdxR", idxR, 0);
    streamFrame(0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/unload_data.md
Name: unload_data

Overview:
- Drain end of the 16-point FFT datapath; the counterpart of loads_data, which presents 16 parallel 32-bit samples with rdy_load.
- Captures one 16-word parallel FFT result frame (x0..x15 style, 32-bit {re[31:16], im[15:0]}) on a ready pulse.
- Streams the frame out one word per transfer over a valid/ready handshake, optionally undoing bit-reversed bin order.
- Sits between the FFT butterfly output stage and the result sink (memory writer / UART / checker).

Parameters:
- DATA_W, 32, width of each complex sample word
- BIT_REV, 1, 1 = output address is the bit-reverse of the stream counter (natural-order bins from a bit-reversed FFT); 0 = straight order

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- enable  input  1  gates acceptance of a new frame only
- rdy_fft  input  1  one-cycle pulse: y0..y15 valid this cycle
- y0..y15  input  DATA_W each  parallel FFT result words
- busy  output  1  frame held / streaming (state != IDLE)
- dout  output  DATA_W  current stream word
- dout_idx  output  4  bin index of dout (buffer address)
- dout_valid  output  1  dout/dout_idx valid
- dout_ready  input  1  sink accepts when high with dout_valid
- dout_last  output  1  high with the 16th word
- done  output  1  one-cycle pulse after the last transfer
- overrun  output  1  sticky: a frame arrived while not IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, cnt=0, buffer cleared to 0, busy=0, dout_valid=0, dout_last=0, done=0, overrun=0, dout=0, dout_idx=0. Reset mid-stream aborts the frame; no partial output after release.
- States: IDLE, STREAM, DONE.
- IDLE: if rdy_fft && enable at edge T, latch y0..y15 into buf[0..15], cnt<=0, go to STREAM. dout_valid=1 from T+1, a 1-cycle capture latency. rdy_fft with enable=0 is ignored, with no flag.
- STREAM:
  - dout_valid=1. addr = BIT_REV ? {cnt[0],cnt[1],cnt[2],cnt[3]} : cnt. dout=buf[addr], dout_idx=addr, both combinational from registers.
  - Transfer = dout_valid && dout_ready. On transfer cnt<=cnt+1.
  - dout_last = (cnt==15). Transfer with cnt==15 goes to DONE, cnt wraps to 0.
  - While valid && !ready, dout/dout_idx/dout_last hold stable; valid never drops before transfer.
  - enable has no effect in STREAM.
- DONE: single cycle, done=1, dout_valid=0, then IDLE.
- Earliest next-frame acceptance is the cycle after DONE. Minimum frame period with ready tied high: 1 (accept) + 16 + 1 = 18 cycles.
- rdy_fft in STREAM or DONE: frame discarded, buffer untouched, overrun<=1. Only reset clears overrun.
- The buffer is written only on accept in IDLE; contents persist after DONE.
- All arithmetic is unsigned 4-bit, and the counter wraps naturally. No data modification: the word passes through bit-exact.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N=16, LOG2N=4, DATA_W default
  - state typedef {IDLE, STREAM, DONE}
  - function bitrev4(cnt), also reusable by loads_data and the 8-point variant with a width argument
- No sub-module needed. Buffer plus FSM sits in one module of roughly 150–200 lines, as 16 registers with a 16:1 mux.

Test Plan:
- Reset/idle: hold reset_n=0 200 ns with rdy_fft pulsing -> all outputs 0, busy=0. After release with no rdy_fft -> dout_valid stays 0.
- Natural order, BIT_REV=0, ready=1: yk={16'(k),16'(0x100+k)}, pulse rdy_fft at T -> dout_valid at T+1. dout sequence 0x00000100, 0x00010101, …, 0x000F010F. dout_idx 0..15; dout_last only on 0x000F010F. done at T+17, busy=0 at T+18.
- Bit-reverse, BIT_REV=1, same data: dout_idx order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with dout=buf[dout_idx] each step.
- Backpressure: dout_ready toggling 1,0,0,1,… and held low 5 cycles at cnt=7 -> dout/dout_idx stable throughout. Exactly 16 transfers, no duplicates or drops, done one cycle after the 16th.
- Overrun/enable: second rdy_fft with new data at cnt=3 -> overrun=1, stream continues with the original frame values. rdy_fft with enable=0 in IDLE -> no capture, overrun stays 0.
- Async reset mid-stream: reset_n low at cnt=9 between edges -> dout_valid=0 and busy=0 immediately. After release a new frame streams from index 0.
